// File: rtl/seq_pkg.sv
// Shared definitions for the BBCCC transmitter and the matching detectors.
package seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SEND = 4'b0010,
    ST_GAP  = 4'b0100,
    ST_FIN  = 4'b1000
  } state_t;

  localparam logic SYM_B = 1'b0;
  localparam logic SYM_C = 1'b1;

  localparam logic [4:0] SEQ_BBCCC = {SYM_B, SYM_B, SYM_C, SYM_C, SYM_C};

  // Index width that still works for a degenerate one-symbol frame.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_bbccc_tx_if.sv
// Control/stream bundle between the pattern transmitter and its user.
interface seq_bbccc_tx_if #(
  parameter int unsigned RCW = 4,
  parameter int unsigned GW  = 4
);
  logic           start;
  logic [RCW-1:0] rep_cnt;
  logic [GW-1:0]  gap_len;
  logic           en;
  logic           dout;
  logic           dout_vld;
  logic           sof;
  logic           busy;
  logic           done;

  modport master (
    output start, rep_cnt, gap_len, en,
    input  dout, dout_vld, sof, busy, done
  );

  modport slave (
    input  start, rep_cnt, gap_len, en,
    output dout, dout_vld, sof, busy, done
  );
endinterface

// File: rtl/seq_dn_cnt.sv
// Loadable down-counter that saturates at zero; zero flag is the terminal count.
module seq_dn_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_bbccc_tx.sv
// Serial BBCCC frame transmitter: rep_cnt frames, MSB first, optional idle gap.
//   state | meaning
//   IDLE  | waiting for start, line at IDLE_BIT
//   SEND  | presenting frame bit bit_idx until an en edge consumes it
//   GAP   | idle bit-times between frames, counted on en edges
//   FIN   | one-cycle done pulse, then back to IDLE
module seq_bbccc_tx
  import seq_pkg::*;
#(
  parameter int unsigned        SEQ_LEN  = 5,
  parameter logic [SEQ_LEN-1:0] SEQ      = SEQ_BBCCC,
  parameter logic               IDLE_BIT = 1'b1,
  parameter int unsigned        RCW      = 4,
  parameter int unsigned        GW       = 4
) (
  input logic           clk,
  input logic           rst,
  seq_bbccc_tx_if.slave bus
);

  localparam int unsigned    IW   = idx_w(SEQ_LEN);
  localparam logic [IW-1:0]  LAST = IW'(SEQ_LEN - 1);

  state_t         state;
  logic [GW-1:0]  gap_lat;
  logic [IW-1:0]  bit_idx;
  logic [IW-1:0]  nxt_idx;
  logic [RCW-1:0] frm_cnt;
  logic [GW-1:0]  gap_cnt;
  logic           bit_zero;
  logic           frm_zero;
  logic           gap_zero;
  logic           in_idle;
  logic           in_send;
  logic           in_gap;
  logic           acc_start;
  logic           frm_end;
  logic           bit_load;
  logic           bit_dec;
  logic           gap_load;
  logic           gap_dec;
  logic           unused_cnt;

  assign in_idle   = (state == ST_IDLE);
  assign in_send   = (state == ST_SEND);
  assign in_gap    = (state == ST_GAP);
  assign acc_start = in_idle && bus.start && (bus.rep_cnt != '0);
  assign frm_end   = in_send && bus.en && bit_zero;

  // Frame counter holds frames still to send after the current one.
  assign bit_load = acc_start
                  || (frm_end && !frm_zero && (gap_lat == '0))
                  || (in_gap && bus.en && gap_zero);
  assign bit_dec  = in_send && bus.en && !bit_zero;
  assign gap_load = frm_end && !frm_zero && (gap_lat != '0);
  assign gap_dec  = in_gap && bus.en && !gap_zero;

  assign nxt_idx = bit_load ? LAST : (bit_dec ? (bit_idx - IW'(1)) : bit_idx);

  // Frame and gap counters are only observed through their zero flags.
  assign unused_cnt = ^{frm_cnt, gap_cnt};

  seq_dn_cnt #(.W(IW)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bit_load),
    .dec      (bit_dec),
    .load_val (LAST),
    .cnt      (bit_idx),
    .zero     (bit_zero)
  );

  seq_dn_cnt #(.W(RCW)) u_frm_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (acc_start),
    .dec      (frm_end),
    .load_val (bus.rep_cnt - RCW'(1)),
    .cnt      (frm_cnt),
    .zero     (frm_zero)
  );

  seq_dn_cnt #(.W(GW)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .dec      (gap_dec),
    .load_val (gap_lat - GW'(1)),
    .cnt      (gap_cnt),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      gap_lat      <= '0;
      bus.dout     <= IDLE_BIT;
      bus.dout_vld <= 1'b0;
      bus.sof      <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.rep_cnt != '0) begin
              state        <= ST_SEND;
              gap_lat      <= bus.gap_len;
              bus.dout     <= SEQ[LAST];
              bus.dout_vld <= 1'b1;
              bus.sof      <= 1'b1;
              bus.busy     <= 1'b1;
            end else begin
              state    <= ST_FIN;
              bus.done <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (frm_end && frm_zero) begin
            state        <= ST_FIN;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            bus.dout_vld <= 1'b0;
            bus.sof      <= 1'b0;
            bus.dout     <= IDLE_BIT;
          end else if (gap_load) begin
            state        <= ST_GAP;
            bus.dout_vld <= 1'b0;
            bus.sof      <= 1'b0;
            bus.dout     <= IDLE_BIT;
          end else begin
            bus.dout <= SEQ[nxt_idx];
            bus.sof  <= (nxt_idx == LAST);
          end
        end
        ST_GAP: begin
          if (bus.en && gap_zero) begin
            state        <= ST_SEND;
            bus.dout     <= SEQ[LAST];
            bus.dout_vld <= 1'b1;
            bus.sof      <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state        <= ST_IDLE;
          bus.dout     <= IDLE_BIT;
          bus.dout_vld <= 1'b0;
          bus.sof      <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bbccc_tx.sv
// Bench for seq_bbccc_tx: directed scenarios plus random traffic against a
// stream-queue model (each accepted start expands into a list of bit/gap/done slots).
module tb_seq_bbccc_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_bbccc_tx_if #(.RCW(4), .GW(4)) bus ();
  seq_bbccc_tx dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [4:0] PAT = 5'b00111;
  localparam logic [1:0] K_BIT = 2'd0, K_GAP = 2'd1, K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic       b;
    logic       first;
  } item_t;

  int errors = 0;
  int checks = 0;

  item_t      q[$];
  logic [4:0] exp_o;   // {dout, dout_vld, sof, busy, done}

  function automatic item_t mk(input logic [1:0] kind, input logic b, input logic first);
    item_t it;
    it.kind = kind; it.b = b; it.first = first;
    return it;
  endfunction

  function automatic logic [4:0] obs_now();
    return {bus.dout, bus.dout_vld, bus.sof, bus.busy, bus.done};
  endfunction

  // Reference: the line presents the head slot; an en edge consumes bit/gap
  // slots, the done slot lasts exactly one cycle, empty queue means idle.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else if (q.size() == 0) begin
      if (bus.start) begin
        for (int f = 0; f < int'(bus.rep_cnt); f++) begin
          if (f > 0)
            for (int g = 0; g < int'(bus.gap_len); g++) q.push_back(mk(K_GAP, 1'b1, 1'b0));
          for (int k = 0; k < 5; k++) q.push_back(mk(K_BIT, PAT[4-k], k == 0));
        end
        q.push_back(mk(K_DONE, 1'b1, 1'b0));
      end
    end else if (q[0].kind == K_DONE || bus.en) begin
      void'(q.pop_front());
    end
    if (q.size() == 0)           exp_o <= 5'b10000;
    else if (q[0].kind == K_BIT) exp_o <= {q[0].b, 1'b1, q[0].first, 1'b1, 1'b0};
    else if (q[0].kind == K_GAP) exp_o <= 5'b10010;
    else                         exp_o <= 5'b10001;
  end

  task automatic test_reset();
    logic [4:0] o;
    rst = 1'b1; bus.start = 1'b1; bus.rep_cnt = 4'd3; bus.gap_len = 4'd0; bus.en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      o = obs_now();
      checks++;
      if (o !== 5'b10000) begin
        errors++; $display("FAIL reset c%0d: got %b want 10000", c, o);
      end
      checks++;
      if (o !== exp_o) begin
        errors++; $display("FAIL reset_model c%0d: got %b want %b", c, o, exp_o);
      end
      if (c == 3) begin rst = 1'b0; bus.start = 1'b0; end
    end
  endtask

  task automatic test_single();
    logic [4:0] o, bits;
    int done_at, nbits, nsof;
    bits = '0; done_at = -1; nbits = 0; nsof = 0;
    bus.start = 1'b1; bus.rep_cnt = 4'd1; bus.gap_len = 4'd0; bus.en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      o = obs_now();
      checks++;
      if (o !== exp_o) begin
        errors++; $display("FAIL single c%0d: got %b want %b", c, o, exp_o);
      end
      if (bus.dout_vld) begin bits = {bits[3:0], bus.dout}; nbits++; end
      if (bus.sof && c == 1) nsof++;
      else if (bus.sof) nsof += 10;
      if (bus.done) done_at = c;
    end
    checks++;
    if (bits !== PAT || nbits != 5) begin
      errors++; $display("FAIL single_bits: got %b/%0d want %b/5", bits, nbits, PAT);
    end
    checks++;
    if (done_at != 6) begin errors++; $display("FAIL single_done: got c%0d want c6", done_at); end
    checks++;
    if (nsof != 1) begin errors++; $display("FAIL single_sof: got code %0d want 1", nsof); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] o;
    logic [9:0] bits;
    logic [15:0] sofm;
    int nbits, hits, done_at;
    bits = '0; sofm = '0; nbits = 0; hits = 0; done_at = -1;
    bus.start = 1'b1; bus.rep_cnt = 4'd2; bus.gap_len = 4'd0; bus.en = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      o = obs_now();
      checks++;
      if (o !== exp_o) begin
        errors++; $display("FAIL b2b c%0d: got %b want %b", c, o, exp_o);
      end
      if (bus.dout_vld) begin bits = {bits[8:0], bus.dout}; nbits++; end
      if (bus.sof) sofm[c] = 1'b1;
      if (bus.done) done_at = c;
    end
    for (int i = 0; i <= 5; i++) if (bits[i +: 5] == PAT) hits++;
    checks++;
    if (bits !== {PAT, PAT} || nbits != 10) begin
      errors++; $display("FAIL b2b_bits: got %b/%0d want %b/10", bits, nbits, {PAT, PAT});
    end
    checks++;
    if (sofm !== 16'h0042) begin errors++; $display("FAIL b2b_sof: got %h want 0042", sofm); end
    checks++;
    if (hits != 2) begin errors++; $display("FAIL b2b_detect: got %0d want 2", hits); end
    checks++;
    if (done_at != 11) begin errors++; $display("FAIL b2b_done: got c%0d want c11", done_at); end
  endtask

  task automatic test_gap();
    logic [4:0] o;
    int done_at, ngap;
    logic [15:0] gapm;
    done_at = -1; ngap = 0; gapm = '0;
    bus.start = 1'b1; bus.rep_cnt = 4'd2; bus.gap_len = 4'd3; bus.en = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      o = obs_now();
      checks++;
      if (o !== exp_o) begin
        errors++; $display("FAIL gap c%0d: got %b want %b", c, o, exp_o);
      end
      if (o == 5'b10010) begin ngap++; gapm[c] = 1'b1; end
      if (bus.done) done_at = c;
    end
    checks++;
    if (ngap != 3 || gapm !== 16'h01C0) begin
      errors++; $display("FAIL gap_slots: got %0d mask %h want 3 mask 01c0", ngap, gapm);
    end
    checks++;
    if (done_at != 14) begin errors++; $display("FAIL gap_done: got c%0d want c14", done_at); end
  endtask

  task automatic test_en_stall();
    logic [4:0] o;
    int done_at, nvld;
    done_at = -1; nvld = 0;
    bus.start = 1'b1; bus.rep_cnt = 4'd1; bus.gap_len = 4'd0; bus.en = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      o = obs_now();
      checks++;
      if (o !== exp_o) begin
        errors++; $display("FAIL stall c%0d: got %b want %b", c, o, exp_o);
      end
      if (bus.dout_vld) nvld++;
      if (bus.done) done_at = c;
      bus.start = 1'b0;
      bus.en = (c % 2 == 0);
    end
    bus.en = 1'b1;
    checks++;
    if (nvld != 10) begin errors++; $display("FAIL stall_hold: got %0d want 10", nvld); end
    checks++;
    if (done_at != 11) begin errors++; $display("FAIL stall_done: got c%0d want c11", done_at); end
  endtask

  task automatic test_zero_rep();
    logic [4:0] o;
    int done_at, act;
    done_at = -1; act = 0;
    bus.start = 1'b1; bus.rep_cnt = 4'd0; bus.gap_len = 4'd2; bus.en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      o = obs_now();
      checks++;
      if (o !== exp_o) begin
        errors++; $display("FAIL zero c%0d: got %b want %b", c, o, exp_o);
      end
      if (bus.dout_vld || bus.sof || bus.busy) act++;
      if (bus.done) done_at = c;
    end
    checks++;
    if (done_at != 1 || act != 0) begin
      errors++; $display("FAIL zero_done: got c%0d active %0d want c1 active 0", done_at, act);
    end
  endtask

  task automatic test_restart_rst();
    logic [4:0] o;
    int ndone;
    ndone = 0;
    bus.start = 1'b1; bus.rep_cnt = 4'd3; bus.gap_len = 4'd0; bus.en = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      o = obs_now();
      checks++;
      if (o !== exp_o) begin
        errors++; $display("FAIL restart c%0d: got %b want %b", c, o, exp_o);
      end
      if (c <= 10 && bus.done) ndone++;
      if (c == 8) begin
        checks++;
        if (o !== 5'b10000) begin errors++; $display("FAIL restart_rst: got %b want 10000", o); end
      end
      if (c == 11) begin
        checks++;
        if (o !== 5'b01110) begin errors++; $display("FAIL restart_first: got %b want 01110", o); end
      end
      bus.start = 1'b0; rst = 1'b0;
      if (c == 4)  begin bus.start = 1'b1; bus.rep_cnt = 4'd0; bus.gap_len = 4'd5; end
      if (c == 7)  rst = 1'b1;
      if (c == 10) begin bus.start = 1'b1; bus.rep_cnt = 4'd1; bus.gap_len = 4'd0; end
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL restart_nodone: got %0d want 0", ndone); end
  endtask

  task automatic test_random();
    logic [4:0] o;
    for (int c = 1; c <= 600; c++) begin
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.rep_cnt = 4'($urandom_range(0, 3));
      bus.gap_len = 4'($urandom_range(0, 3));
      bus.en      = ($urandom_range(0, 4) != 0);
      rst         = ($urandom_range(0, 79) == 0);
      @(negedge clk);
      o = obs_now();
      checks++;
      if (o !== exp_o) begin
        errors++; $display("FAIL random c%0d: got %b want %b", c, o, exp_o);
      end
    end
    rst = 1'b0; bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.rep_cnt = '0; bus.gap_len = '0; bus.en = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_en_stall();
    test_zero_rep();
    test_restart_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
